uart_echo_buf: RTL

Buffered, parametrised UART echo engine sitting between the `uart` core's RX and TX strobe interfaces in a top-level design. Received bytes are optionally case-transformed, queued in a DEPTH-entry FIFO and retransmitted in order, one at a time, using the `uart` start/done handshake. Back-to-back RX bytes are no longer lost while TX is busy. Overflow and framing-error events are counted, and TX can be paused.

---
 rtl/uart_echo_buf.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_echo_buf
// Description : Buffered UART echo engine. RX bytes are case-transformed,
//               queued in a FIFO and retransmitted over the start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         tx_en,
    input  logic                         rx_strobe,
    input  logic                         rx_done,
    input  logic                         rx_err,
    input  logic [DATA_WIDTH-1:0]        rx_data,
    input  logic                         tx_strobe,
    input  logic                         tx_done,
    output logic                         tx_start,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_WIDTH-1:0]         overflow_cnt,
    output logic [CNT_WIDTH-1:0]         err_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = $clog2(DEPTH + 1);

    localparam logic [c_ADDR_W-1:0]  c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0]   c_LVL_NEAR = c_LVL_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SEND    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  r_full;
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [CNT_WIDTH-1:0]  r_ovf_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;

    logic                  w_rx_evt;
    logic                  w_push;
    logic                  w_push_ok;
    logic                  w_pop;
    logic                  w_tx_start;
    logic [DATA_WIDTH-1:0] w_push_data;

    assign w_rx_evt  = rx_strobe & rx_done;
    assign w_push    = w_rx_evt & ~rx_err;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = w_push & (~r_full | w_pop);

    generate
        if (DATA_WIDTH == 8) begin : g_xform
            logic w_is_up;
            logic w_is_lo;
            always_comb begin
                w_is_up     = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
                w_is_lo     = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
                w_push_data = rx_data;
                if (w_is_up || w_is_lo) begin
                    case (mode)
                        2'd1:    w_push_data[5] = 1'b0;
                        2'd2:    w_push_data[5] = 1'b1;
                        2'd3:    w_push_data[5] = ~rx_data[5];
                        default: w_push_data[5] = rx_data[5];
                    endcase
                end
            end
        end else begin : g_pass
            logic w_unused_mode;
            assign w_unused_mode = ^mode;
            assign w_push_data   = rx_data;
        end
    endgenerate

    // TX handshake FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX handshake FSM: next state; RELEASE waits for the core to see start drop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (tx_en && !r_empty)      w_state_nxt = c_SEND;
            c_SEND:    if (tx_strobe && tx_done)   w_state_nxt = c_RELEASE;
            c_RELEASE: if (tx_strobe && !tx_done)  w_state_nxt = c_IDLE;
            default:                               w_state_nxt = c_IDLE;
        endcase
    end

    // TX handshake FSM: outputs
    always_comb begin
        w_pop      = (r_state == c_IDLE) && tx_en && !r_empty;
        w_tx_start = (r_state == c_SEND);
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_tx_data <= '0;
            r_ovf_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_push_ok, w_pop})
                2'b10: begin
                    r_level <= r_level + c_LVL_ONE;
                    r_empty <= 1'b0;
                    r_full  <= (r_level == c_LVL_NEAR);
                end
                2'b01: begin
                    r_level <= r_level - c_LVL_ONE;
                    r_full  <= 1'b0;
                    r_empty <= (r_level == c_LVL_ONE);
                end
                default: begin
                    r_level <= r_level;
                end
            endcase
            if (w_push && r_full && !w_pop && !(&r_ovf_cnt)) begin
                r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
            end
            if (w_rx_evt && rx_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign tx_start     = w_tx_start;
    assign tx_data      = r_tx_data;
    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign overflow_cnt = r_ovf_cnt;
    assign err_cnt      = r_err_cnt;

    // Unused level encodings above DEPTH never occur; c_LVL_FULL documents the ceiling.
    logic w_unused_lvl;
    assign w_unused_lvl = ^c_LVL_FULL;

endmodule
`default_nettype wire
